// File: rtl/dp_ram_be.sv
// ---------------------------------------------------------------------------
// dp_ram_be
// Simple dual-port RAM: one write port (A) and one read port (B).
// Features: per-byte write masks, an optional extra output register,
// selectable read-during-write behaviour, a read-valid strobe and a
// post-reset sequencer that zeroes every word.
//
// Ports:
//   Clk         in   rising-edge clock
//   Rst_n       in   asynchronous active-low reset
//   write_ena   in   write request on port A
//   we_mask     in   per-lane write enable (NB bits)
//   addr_a      in   write address
//   din_a       in   write data
//   read_ena    in   read request on port B
//   addr_b      in   read address
//   dout_b      out  read data, held between reads
//   dout_valid  out  one-cycle strobe marking new dout_b
//   init_busy   out  high while the clear sequencer runs
// ---------------------------------------------------------------------------
module dp_ram_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 256,
    parameter int BYTE_W         = 8,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = DATA_WIDTH / BYTE_W,
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  write_ena,
    input  logic [NB-1:0]         we_mask,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic                  read_ena,
    input  logic [AW-1:0]         addr_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  dout_valid,
    output logic                  init_busy
);

    // Lane masking only makes sense when the word splits evenly into lanes.
    if ((DATA_WIDTH % BYTE_W) != 0) begin : g_bad_width
        $error("dp_ram_be: DATA_WIDTH must be a multiple of BYTE_W");
    end

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

    // Depth and last index expressed at address width (+1 bit for the
    // range compare) so non-power-of-2 depths are handled cleanly.
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned LAST_U  = DEPTH - 1;
    localparam logic [AW:0]   DEPTH_W = DEPTH_U[AW:0];
    localparam logic [AW-1:0] LAST_IDX = LAST_U[AW-1:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  ready;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_fire;
    logic                  rd_fire;

    assign ready       = (state_q == ST_READY);
    assign wr_in_range = ({1'b0, addr_a} < DEPTH_W);
    assign rd_in_range = ({1'b0, addr_b} < DEPTH_W);
    assign wr_fire     = ready && write_ena && wr_in_range;
    assign rd_fire     = ready && read_ena;
    assign init_busy   = (state_q == ST_INIT);

    // Next-state logic for the clear sequencer: walk cnt over every word,
    // then hand over to normal operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_IDX) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Sequencer state registers; reset always restarts the clear at word 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory array: zeroed one word per cycle during INIT, otherwise
    // written lane by lane. Out-of-range writes are simply dropped.
    always_ff @(posedge Clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (we_mask[i]) begin
                    mem[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Word presented to the read pipeline. Out-of-range reads yield zero.
    // In write-through mode a same-address write forwards its enabled lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[addr_b];
        end
        if ((RDW_MODE != 0) && wr_fire && (addr_a == addr_b)) begin
            for (int i = 0; i < NB; i++) begin
                if (we_mask[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = din_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage: captures the word on an accepted read, holds it
    // otherwise, and strobes valid for exactly one cycle per read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        // Optional second stage: delays data and strobe by one more cycle.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign dout_b     = s2_data_q;
        assign dout_valid = s2_valid_q;
    end else begin : g_no_out_reg
        assign dout_b     = s1_data_q;
        assign dout_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_be
// Directed self-checking bench for dp_ram_be. Three instances share the
// same stimulus:
//   u0: DEPTH=16, OUT_REG=0, RDW_MODE=0
//   u1: DEPTH=16, OUT_REG=1, RDW_MODE=1
//   u2: DEPTH=12, OUT_REG=0, RDW_MODE=0 (addresses 12..15 are out of range)
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_dp_ram_be;

    logic        Clk;
    logic        Rst_n;
    logic        write_ena;
    logic [3:0]  we_mask;
    logic [3:0]  addr_a;
    logic [31:0] din_a;
    logic        read_ena;
    logic [3:0]  addr_b;

    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;

    int checks;
    int failures;

    dp_ram_be #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(0),
                .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .write_ena(write_ena), .we_mask(we_mask),
        .addr_a(addr_a), .din_a(din_a), .read_ena(read_ena), .addr_b(addr_b),
        .dout_b(d0), .dout_valid(v0), .init_busy(b0)
    );

    dp_ram_be #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(1),
                .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .write_ena(write_ena), .we_mask(we_mask),
        .addr_a(addr_a), .din_a(din_a), .read_ena(read_ena), .addr_b(addr_b),
        .dout_b(d1), .dout_valid(v1), .init_busy(b1)
    );

    dp_ram_be #(.DATA_WIDTH(32), .DEPTH(12), .BYTE_W(8), .OUT_REG(0),
                .RDW_MODE(0), .CLEAR_ON_RESET(1)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .write_ena(write_ena), .we_mask(we_mask),
        .addr_a(addr_a), .din_a(din_a), .read_ena(read_ena), .addr_b(addr_b),
        .dout_b(d2), .dout_valid(v2), .init_busy(b2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive all request inputs to their inactive values.
    task automatic idleInputs();
        write_ena = 1'b0;
        we_mask   = 4'h0;
        addr_a    = 4'h0;
        din_a     = 32'h0;
        read_ena  = 1'b0;
        addr_b    = 4'h0;
    endtask

    // Present one cycle of requests, let one rising edge consume them and
    // return on the following falling edge with the inputs idle again.
    task automatic applyStimulus(input logic we, input logic [3:0] mask,
                                 input logic [3:0] aa, input logic [31:0] da,
                                 input logic re, input logic [3:0] ab);
        write_ena = we;
        we_mask   = mask;
        addr_a    = aa;
        din_a     = da;
        read_ena  = re;
        addr_b    = ab;
        @(negedge Clk);
        idleInputs();
    endtask

    // Called right after reset release: count cycles each instance reports
    // init_busy, optionally inject a write+read to addr 2 while clearing,
    // and note whether any read strobe appears during the window.
    task automatic countInit(input bit inject, output int n0, output int n1,
                             output int n2, output bit sawValid);
        n0 = 0;
        n1 = 0;
        n2 = 0;
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (b0) n0++;
            if (b1) n1++;
            if (b2) n2++;
            if (v0 || v1 || v2) sawValid = 1'b1;
            if (inject && (i == 3)) begin
                write_ena = 1'b1;
                we_mask   = 4'hF;
                addr_a    = 4'd2;
                din_a     = 32'h0000DEAD;
                read_ena  = 1'b1;
                addr_b    = 4'd2;
            end else begin
                idleInputs();
            end
            @(negedge Clk);
        end
    endtask

    int  n0, n1, n2;
    bit  sawValid;

    // Linear sequence of directed steps.
    initial begin
        checks   = 0;
        failures = 0;
        Rst_n    = 1'b0;
        idleInputs();
        repeat (2) @(negedge Clk);

        // Reset state
        checkOutput("rst_dout",  d0, 32'h0);
        checkOutput("rst_valid", {31'b0, v0}, 32'h0);
        checkOutput("rst_busy0", {31'b0, b0}, 32'h1);
        checkOutput("rst_busy1", {31'b0, b1}, 32'h1);
        checkOutput("rst_busy2", {31'b0, b2}, 32'h1);

        // Clear sequence with requests injected while busy
        Rst_n = 1'b1;
        countInit(1'b1, n0, n1, n2, sawValid);
        checkOutput("init_len_u0", n0, 32'd16);
        checkOutput("init_len_u1", n1, 32'd16);
        checkOutput("init_len_u2", n2, 32'd12);
        checkOutput("init_no_valid", {31'b0, sawValid}, 32'h0);
        checkOutput("init_dout_zero", d0, 32'h0);

        // Every word reads back as zero after the clear (addr 2 write dropped)
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0]);
            checkOutput("clear_rd_valid", {31'b0, v0}, 32'h1);
            checkOutput("clear_rd_data", d0, 32'h0);
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2);
        checkOutput("init_wr_dropped", d0, 32'h0);
        @(negedge Clk);

        // Byte-lane masking
        applyStimulus(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        checkOutput("mask_u0_data", d0, 32'hAA22CC44);
        checkOutput("mask_u0_valid", {31'b0, v0}, 32'h1);
        checkOutput("mask_u1_not_yet", {31'b0, v1}, 32'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'd0);
        checkOutput("mask_u0_strobe_drop", {31'b0, v0}, 32'h0);
        checkOutput("mask_u0_hold", d0, 32'hAA22CC44);
        checkOutput("mask_u1_valid", {31'b0, v1}, 32'h1);
        checkOutput("mask_u1_data", d1, 32'hAA22CC44);
        applyStimulus(1'b1, 4'b0000, 4'd3, 32'hFFFFFFFF, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        checkOutput("mask_zero_noop", d0, 32'hAA22CC44);

        // Streaming reads, latency 1 on u0 and latency 2 on u1
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b1, 4'hF, a[3:0], 32'h10 + a, 1'b0, 4'd0);
        end
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0]);
            checkOutput("stream_u0_data", d0, 32'h10 + a);
            checkOutput("stream_u0_valid", {31'b0, v0}, 32'h1);
            if (a >= 1) begin
                checkOutput("stream_u1_data", d1, 32'h10 + a - 1);
                checkOutput("stream_u1_valid", {31'b0, v1}, 32'h1);
            end else begin
                checkOutput("stream_u1_first_idle", {31'b0, v1}, 32'h0);
            end
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'd0);
        checkOutput("stream_u0_end", {31'b0, v0}, 32'h0);
        checkOutput("stream_u1_last", d1, 32'h13);
        checkOutput("stream_u1_last_valid", {31'b0, v1}, 32'h1);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'd0);
        checkOutput("stream_u1_end", {31'b0, v1}, 32'h0);
        checkOutput("stream_u1_hold", d1, 32'h13);

        // Read-during-write to the same address
        applyStimulus(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        checkOutput("rdw_old_u0", d0, 32'h12345678);
        checkOutput("rdw_old_u2", d2, 32'h12345678);
        applyStimulus(1'b1, 4'hF, 4'd6, 32'hA5A5A5A5, 1'b1, 4'd5);
        checkOutput("rdw_new_u1", d1, 32'h1234FFFF);
        checkOutput("rdw_after_u0", d0, 32'h1234FFFF);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'd0);
        checkOutput("rdw_diff_addr_u1", d1, 32'h1234FFFF);
        checkOutput("rdw_diff_addr_valid", {31'b0, v1}, 32'h1);

        // Out-of-range address on the 12-word instance
        applyStimulus(1'b1, 4'hF, 4'd14, 32'hCAFEF00D, 1'b0, 4'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd14);
        checkOutput("oor_inrange_u0", d0, 32'hCAFEF00D);
        checkOutput("oor_data_u2", d2, 32'h0);
        checkOutput("oor_valid_u2", {31'b0, v2}, 32'h1);

        // Reset with a read still in flight in the two-stage instance
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        checkOutput("flight_u0_data", d0, 32'h13);
        Rst_n = 1'b0;
        #1;
        checkOutput("flight_rst_d0", d0, 32'h0);
        checkOutput("flight_rst_v0", {31'b0, v0}, 32'h0);
        checkOutput("flight_rst_d1", d1, 32'h0);
        checkOutput("flight_rst_v1", {31'b0, v1}, 32'h0);
        @(negedge Clk);
        checkOutput("flight_no_late_v1", {31'b0, v1}, 32'h0);

        // Reset asserted part-way through the clear (cnt = 7)
        Rst_n = 1'b1;
        repeat (7) @(negedge Clk);
        checkOutput("midinit_busy", {31'b0, b0}, 32'h1);
        Rst_n = 1'b0;
        #1;
        checkOutput("midinit_rst_busy", {31'b0, b0}, 32'h1);
        checkOutput("midinit_rst_dout", d0, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        countInit(1'b0, n0, n1, n2, sawValid);
        checkOutput("reinit_len_u0", n0, 32'd16);
        checkOutput("reinit_len_u1", n1, 32'd16);
        checkOutput("reinit_len_u2", n2, 32'd12);

        // Memory was cleared again
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        checkOutput("reinit_rd_data", d0, 32'h0);
        checkOutput("reinit_rd_valid", {31'b0, v0}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
